integrator_rr_scheduler: RTL and testbench

//  Shares one averaging-integrator datapath among NUM_CH sample streams.
//  - Round-robin arbiter grants at most one channel per cycle.
//  - Per-channel previous-sample history is stored locally.
//  - Emits out = (in + hist[ch]) / 2, tagged with the channel index.
//  - Sits between the per-channel front-end filters and the shared decimation/output stage.

---
 rtl/integrator_rr_scheduler.sv | 165 ++++++++++++++++
 tb/tb_integrator_rr_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/integrator_rr_scheduler.sv
// integrator_rr_scheduler
//   Shares one averaging-integrator datapath among NUM_CH sample streams.
//   A round-robin arbiter grants at most one channel per cycle. The granted
//   sample is averaged with that channel's previous sample. The result is
//   registered with its channel tag, one cycle after the accept.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   en         global enable (low: no grants, history held except clears)
//   ch_valid   per-channel sample valid
//   ch_data    packed samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_ready   combinational one-hot grant (zero when nothing is granted)
//   ch_clear   per-channel history clear
//   out_data   signed averaged sample
//   out_ch     channel index of out_data
//   out_valid  out_data/out_ch valid
//   out_ready  downstream accept
//
// Build option
//   INTEG_ROUND_EN  round half up, (sum+1)>>>1, clamped to max positive.
//                   When undefined, the result is the truncating sum>>>1.

// Per-channel history register. An accept wins over a clear, so a
// simultaneous clear and accept leaves the new sample stored.
module integrator_hist_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] hist
);
    always_ff @(posedge clk) begin
        if (rst)      hist <= '0;
        else if (acc) hist <= din;
        else if (clr) hist <= '0;
    end
endmodule

module integrator_rr_scheduler #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_CH     = 4,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_ready,
    input  logic [NUM_CH-1:0]            ch_clear,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CH_W-1:0]       ch;
    } out_t;

    out_t                                 out_q;
    logic [CH_W-1:0]                      rr_ptr;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_data_v;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    hist_q;
    logic [NUM_CH-1:0]                    rot;
    logic [CH_W:0]                        wrap_idx;
    logic [CH_W-1:0]                      grant_idx;
    logic                                 found;
    logic                                 slot_free;
    logic                                 grant;
    logic [DATA_WIDTH-1:0]                sel_in;
    logic [DATA_WIDTH-1:0]                sel_h;
    logic signed [DATA_WIDTH:0]           sum;
    logic [DATA_WIDTH-1:0]                avg;

    assign ch_data_v = ch_data;

    // ---------------- arbitration ----------------
    assign slot_free = !out_valid || out_ready;

    // Rotate the request vector so bit 0 is the channel at rr_ptr. The
    // lowest set bit is then the winner. Map it back modulo NUM_CH.
    always_comb begin
        rot       = NUM_CH'({ch_valid, ch_valid} >> rr_ptr);
        found     = 1'b0;
        wrap_idx  = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && rot[i]) begin
                found    = 1'b1;
                wrap_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
                if (wrap_idx >= (CH_W+1)'(NUM_CH))
                    wrap_idx = wrap_idx - (CH_W+1)'(NUM_CH);
                grant_idx = wrap_idx[CH_W-1:0];
            end
        end
    end

    assign grant    = !rst && en && slot_free && found;
    assign ch_ready = grant ? (NUM_CH'(1) << grant_idx) : '0;

    // ---------------- per-channel history ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        integrator_hist_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .acc  (ch_ready[g]),
            .clr  (ch_clear[g]),
            .din  (ch_data_v[g]),
            .hist (hist_q[g])
        );
    end

    // ---------------- datapath ----------------
    // A clear in the same cycle as the accept averages against zero.
    always_comb begin
        sel_in = ch_data_v[grant_idx];
        sel_h  = ch_clear[grant_idx] ? '0 : hist_q[grant_idx];
        sum    = $signed({sel_in[DATA_WIDTH-1], sel_in}) +
                 $signed({sel_h[DATA_WIDTH-1], sel_h});
    end

`ifdef INTEG_ROUND_EN
    localparam logic signed [DATA_WIDTH+1:0] MAX_POS = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]        MAX_OUT = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic signed [DATA_WIDTH+1:0] sum_r;
    logic signed [DATA_WIDTH+1:0] shr_r;

    // Two extra bits so the +1 cannot wrap. The clamp guards the top end.
    always_comb begin
        sum_r = $signed({sum[DATA_WIDTH], sum}) + $signed((DATA_WIDTH+2)'(1));
        shr_r = sum_r >>> 1;
        avg   = (shr_r > MAX_POS) ? MAX_OUT : DATA_WIDTH'(shr_r);
    end
`else
    // Arithmetic shift floors. The sum of two in-range values halves back into range.
    always_comb avg = DATA_WIDTH'(sum >>> 1);
`endif

    // ---------------- output register / pointer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (grant) begin
            out_q.data <= avg;
            out_q.ch   <= grant_idx;
            out_valid  <= 1'b1;
            rr_ptr     <= (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data = out_q.data;
    assign out_ch   = out_q.ch;
endmodule

// File: tb/tb_integrator_rr_scheduler.sv
// Testbench for integrator_rr_scheduler. It runs directed scenarios first,
// then randomized traffic. Each cycle the outputs are checked against a
// behavioural model made of a round-robin pointer, history array and output slot.
module tb_integrator_rr_scheduler;
    localparam int DW = 16;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst, en, out_valid, out_ready;
    logic [N-1:0]  ch_valid, ch_ready, ch_clear;
    logic [N*DW-1:0] ch_data;
    logic [DW-1:0] out_data;
    logic [1:0]    out_ch;

    integrator_rr_scheduler #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .ch_clear(ch_clear), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int m_hist[N];
    int m_rr;
    bit m_valid;
    int m_data;
    int m_ch;
    bit m_live = 1'b0;

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fdiv2(int s);
        return (s < 0 && (s % 2) != 0) ? s / 2 - 1 : s / 2;
    endfunction

    function automatic int average(int a, int b);
        int r;
`ifdef INTEG_ROUND_EN
        r = fdiv2(a + b + 1);
        if (r > 32767) r = 32767;
`else
        r = fdiv2(a + b);
`endif
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pk(int ch, int val);
        logic [N*DW-1:0] w;
        logic [DW-1:0]   v;
        w = '0;
        v = DW'(val);
        w[ch*DW +: DW] = v;
        return w;
    endfunction

    function automatic int lane(logic [N*DW-1:0] d, int ch);
        logic [DW-1:0] v;
        v = d[ch*DW +: DW];
        return int'($signed(v));
    endfunction

    // Compare the present outputs with the model, then advance the model
    // across the coming clock edge using the inputs now applied.
    task automatic model_step();
        int  w;
        bit  grant;
        int  exp_ready;
        int  h;
        if (m_live) begin
            chk("out_valid", int'(out_valid), int'(m_valid));
            if (m_valid) begin
                chk("out_data", int'($signed(out_data)), m_data);
                chk("out_ch", int'(out_ch), m_ch);
            end
        end
        w = -1;
        for (int off = 0; off < N; off++)
            if (w < 0 && ch_valid[(m_rr + off) % N]) w = (m_rr + off) % N;
        grant     = !rst && en && (!m_valid || out_ready) && (w >= 0);
        exp_ready = grant ? (1 << w) : 0;
        chk("ch_ready", int'(ch_ready), exp_ready);

        if (rst) begin
            foreach (m_hist[j]) m_hist[j] = 0;
            m_rr = 0; m_valid = 1'b0; m_data = 0; m_ch = 0; m_live = 1'b1;
        end else begin
            if (grant) begin
                h       = ch_clear[w] ? 0 : m_hist[w];
                m_data  = average(lane(ch_data, w), h);
                m_ch    = w;
                m_valid = 1'b1;
                m_rr    = (w + 1) % N;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            for (int j = 0; j < N; j++) begin
                if (grant && j == w) m_hist[j] = lane(ch_data, j);
                else if (ch_clear[j]) m_hist[j] = 0;
            end
        end
    endtask

    task automatic cyc(bit r, bit e, logic [N-1:0] v, logic [N*DW-1:0] d,
                       logic [N-1:0] c, bit ordy);
        rst = r; en = e; ch_valid = v; ch_data = d; ch_clear = c; out_ready = ordy;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N*DW-1:0] rd;
        logic [N-1:0]    rv, rc;
        logic [DW-1:0]   s;
        rst = 1'b1; en = 1'b0; ch_valid = '0; ch_data = '0; ch_clear = '0; out_ready = 1'b1;

        // 1: reset with all requesters active, then the first grant goes to ch0
        cyc(1, 1, 4'hF, '0, '0, 1);
        cyc(1, 1, 4'hF, '0, '0, 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        cyc(0, 1, 4'hF, '0, '0, 1);
        chk("first_grant_ch", int'(out_ch), 0);

        // 2: ch0 sends 100 then 200
        cyc(1, 0, '0, '0, '0, 1);
        cyc(0, 1, 4'h1, pk(0, 100), '0, 1);
        chk("t2_first", int'($signed(out_data)), 50);
        cyc(0, 1, 4'h1, pk(0, 200), '0, 1);
        chk("t2_second", int'($signed(out_data)), 150);
        cyc(0, 1, 4'h0, '0, '0, 1);

        // 3: all channels continuously valid
        for (int i = 0; i < 9; i++)
            cyc(0, 1, 4'hF, pk(0, i) | pk(1, -i) | pk(2, 7*i) | pk(3, 1000), '0, 1);

        // 4: backpressure hold, then release grants in the same cycle
        cyc(0, 1, 4'hF, pk(1, 40), '0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 4'hF, pk(1, 40), '0, 0);
            chk("t4_hold_valid", int'(out_valid), 1);
        end
        cyc(0, 1, 4'hF, pk(1, 40), '0, 1);

        // 5: clear coincident with accept
        cyc(1, 0, '0, '0, '0, 1);
        cyc(0, 1, 4'h4, pk(2, 1000), '0, 1);
        cyc(0, 1, 4'h4, pk(2, 3000), 4'h4, 1);
        chk("t5_clear_acc", int'($signed(out_data)), 1500);
        cyc(0, 1, 4'h4, pk(2, 1000), '0, 1);
        chk("t5_after", int'($signed(out_data)), 2000);

        // 6: most-negative values, negative rounding
        cyc(0, 1, 4'h2, pk(1, -32768), '0, 1);
        cyc(0, 1, 4'h2, pk(1, -32768), '0, 1);
        chk("t6_minneg", int'($signed(out_data)), -32768);
        cyc(0, 1, 4'h2, pk(1, 0), '0, 1);
        cyc(0, 1, 4'h2, pk(1, -3), '0, 1);
`ifdef INTEG_ROUND_EN
        chk("t6_neg3", int'($signed(out_data)), -1);
`else
        chk("t6_neg3", int'($signed(out_data)), -2);
`endif
        cyc(0, 1, 4'h2, pk(1, 32767), '0, 1);
        cyc(0, 1, 4'h2, pk(1, 32767), '0, 1);
        chk("t6_maxpos", int'($signed(out_data)), 32767);

        // en low: output drains, clears still act
        cyc(0, 0, 4'hF, '0, 4'h2, 1);
        cyc(0, 0, 4'hF, '0, '0, 1);
        chk("en0_drained", int'(out_valid), 0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rv = N'($urandom);
            rc = N'($urandom) & N'($urandom) & N'($urandom);
            rd = '0;
            for (int j = 0; j < N; j++) begin
                case ($urandom_range(0, 7))
                    0:       s = 16'h8000;
                    1:       s = 16'h7FFF;
                    default: s = DW'($urandom);
                endcase
                rd[j*DW +: DW] = s;
            end
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, rv, rd, rc,
                $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
